pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Eight-channel PWM pulse-width decoder, the receive-side counterpart of the on-chip PWM generator.
- Measures the high time of each RC receiver or servo-style PWM input in whole microseconds.
- Each channel presents the last good width with a valid flag and a one-cycle update strobe, for the FCU register/bus logic to read.
- Runs on the 50 MHz PLL system clock.

Parameters:
- CLK_PER_US, 50: system clocks per microsecond; the µs tick prescaler wraps at CLK_PER_US-1.
- MIN_US, 500: shortest accepted pulse, in µs; shorter pulses are rejected as glitches.
- MAX_US, 2500: longest accepted pulse, in µs; longer pulses are rejected.
- TIMEOUT_US, 25000: µs without an accepted pulse before a channel is declared lost.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RSTn  in  1  asynchronous active-low reset.
- En  in  1  capture enable; 0 holds all channels cleared.
- Sig_In1..Sig_In8  in  1 each  asynchronous PWM inputs, active-high pulses.
- Width1..Width8  out  16 each  last accepted pulse width in µs; 0 when not valid.
- Valid  out  8  bit n-1 = channel n has an accepted pulse within TIMEOUT_US.
- Update  out  8  bit n-1 pulses high for one CLK when Width n is written by an accepted pulse.

Behaviour:
- Reset (RSTn=0, asynchronous): all Width=0, Valid=0, Update=0; synchronisers, counters and channel state cleared. This applies mid-pulse too; a falling edge seen after reset with no preceding rise is ignored.
- Input path: per channel, a 2-flop synchroniser s1→s2 plus a history flop s3.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- Channel state machine: IDLE → (rise) → HIGH → (fall) → IDLE.
- Per-channel counters: sub (0..CLK_PER_US-1) and us (16 bit).
  - On rise: sub<=1, us<=0.
  - In HIGH with s2=1: if sub==CLK_PER_US-1 then sub<=0, us<=us+1; else sub<=sub+1.
  - us saturates at MAX_US+1 and does not wrap.
  - A rise seen while in HIGH (impossible after sync) is ignored.
- Fall handling: the measured value is M = us + (sub >= CLK_PER_US/2), i.e. round to nearest µs.
  - Accept if MIN_US <= M <= MAX_US: Width<=M, Valid<=1, Update<=1 for one cycle, timeout timer cleared.
  - Reject otherwise: Width, Valid and timer are unchanged, and there is no Update.
- Latency: let edge k be the first CLK edge that samples the pin low. Width and Update are visible after edge k+2; Update deasserts after edge k+3.
- Timeout timer:
  - A single shared µs prescaler (0..CLK_PER_US-1) produces a one-cycle tick.
  - A per-channel 16-bit timer increments on each tick and saturates at TIMEOUT_US.
  - When the timer reaches TIMEOUT_US: Valid<=0 and Width<=0 (matching the generator's "0 = off" convention).
  - A measurement in progress continues; a later accepted fall restores Valid.
- Simultaneous events: if an accepted fall and timer expiry occur in the same cycle, the accept wins: Valid=1, Width=M, timer=0.
- En=0 (synchronous): same effect as reset on all state except the shared prescaler, which is also held at 0. Outputs go to 0 on the next edge. On re-enable, channels start in IDLE.
- A continuously high or continuously low input produces no Update, and Valid drops TIMEOUT_US (±1 µs) after the last accept.
- Channels are fully independent; all eight may update in the same cycle.

Test Plan:
- Reset then En=1; drive Sig_In1 high for 1500×50 clocks, then low → Width1=1500, Valid[0]=1, one-cycle Update[0] at edge k+2; other channels remain 0.
- High for 1500×50+24 clocks → Width=1500; high for 1500×50+25 clocks → Width=1501 (rounding boundary).
- Pulses of 499 µs and 2501 µs after a good 1000 µs pulse → no Update, Width stays 1000, Valid stays 1; pulses of exactly 500 µs and 2500 µs are accepted.
- Accept 1200 µs on ch3, then hold the input low → Valid[2] and Width3 stay until 25000 µs after the accepted fall (±1 µs), then Valid[2]=0, Width3=0; the next 1100 µs pulse restores Valid[2]=1, Width3=1100.
- All 8 channels driven with widths 1000, 1100, …, 1700 µs at 2.5 ms period, with phases skewed and some falls coincident → every channel reports its exact width each period; coincident Updates are all seen.
- Assert RSTn=0 mid-pulse, release, let the pulse fall → no Update; the next full 1800 µs pulse gives Width=1800. Dropping En mid-pulse gives the same result, with outputs cleared one edge after En=0.

Source files
------------

// File: rtl/pwm_capture.sv
// Eight-channel PWM pulse-width decoder.
// Each lane synchronises its pin, times the high phase in microseconds
// (rounded to nearest), accepts widths inside [MIN_US, MAX_US], and drops
// its valid flag once TIMEOUT_US passes without an accepted pulse.

module pwm_capture_ch #(
  parameter int CLK_PER_US = 50,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int TIMEOUT_US = 25000,
  parameter int SW         = 6
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        i_en,
  input  logic        i_tick,
  input  logic        i_sig,
  output logic [15:0] o_width,
  output logic        o_valid,
  output logic        o_update
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HIGH = 1'b1} state_t;

  localparam logic [SW-1:0] SUB_MAX = SW'(CLK_PER_US - 1);
  localparam logic [SW-1:0] HALF    = SW'(CLK_PER_US / 2);
  localparam logic [15:0]   MIN_W   = 16'(MIN_US);
  localparam logic [15:0]   MAX_W   = 16'(MAX_US);
  localparam logic [15:0]   US_SAT  = 16'(MAX_US + 1);
  localparam logic [15:0]   TMO_W   = 16'(TIMEOUT_US);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_sync;            // [0]=s1, [1]=s2, [2]=s3 (history)
  logic [SW-1:0] r_sub;
  logic [15:0]   r_us;
  logic [15:0]   r_tmr;
  logic [15:0]   r_width;
  logic          r_valid;
  logic          r_update;
  logic          w_rise, w_fall, w_accept, w_expire;
  logic [15:0]   w_meas;

  assign w_rise   = r_sync[1] & ~r_sync[2];
  assign w_fall   = ~r_sync[1] & r_sync[2];
  // Round to the nearest microsecond using the leftover sub-count.
  assign w_meas   = r_us + 16'(r_sub >= HALF);
  assign w_accept = (r_state == ST_HIGH) && w_fall &&
                    (w_meas >= MIN_W) && (w_meas <= MAX_W);
  assign w_expire = i_tick && (r_tmr == TMO_W - 16'd1);

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)      r_sync <= '0;
    else if (!i_en) r_sync <= '0;
    else            r_sync <= {r_sync[1:0], i_sig};
  end

  // Channel state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)      r_state <= ST_IDLE;
    else if (!i_en) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state: a rise arms the measurement, a fall ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_fall) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // High-time counters; the rise cycle itself counts as the first clock.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sub <= '0;
      r_us  <= '0;
    end else if (!i_en) begin
      r_sub <= '0;
      r_us  <= '0;
    end else if (r_state == ST_IDLE && w_rise) begin
      r_sub <= SW'(1);
      r_us  <= '0;
    end else if (r_state == ST_HIGH && r_sync[1]) begin
      if (r_sub == SUB_MAX) begin
        r_sub <= '0;
        if (r_us != US_SAT) r_us <= r_us + 16'd1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

  // Loss-of-signal timer: cleared by an accept, otherwise saturating count.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                         r_tmr <= '0;
    else if (!i_en)                    r_tmr <= '0;
    else if (w_accept)                 r_tmr <= '0;
    else if (i_tick && r_tmr != TMO_W) r_tmr <= r_tmr + 16'd1;
  end

  // Result registers; an accept in the expiry cycle takes priority.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_width  <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
    end else if (!i_en) begin
      r_width  <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_accept;
      if (w_accept) begin
        r_width <= w_meas;
        r_valid <= 1'b1;
      end else if (w_expire) begin
        r_width <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_width  = r_width;
  assign o_valid  = r_valid;
  assign o_update = r_update;

endmodule

module pwm_capture #(
  parameter int CLK_PER_US = 50,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        En,
  input  logic        Sig_In1,
  input  logic        Sig_In2,
  input  logic        Sig_In3,
  input  logic        Sig_In4,
  input  logic        Sig_In5,
  input  logic        Sig_In6,
  input  logic        Sig_In7,
  input  logic        Sig_In8,
  output logic [15:0] Width1,
  output logic [15:0] Width2,
  output logic [15:0] Width3,
  output logic [15:0] Width4,
  output logic [15:0] Width5,
  output logic [15:0] Width6,
  output logic [15:0] Width7,
  output logic [15:0] Width8,
  output logic [7:0]  Valid,
  output logic [7:0]  Update
);

  localparam int NUM_LANES = 8;
  localparam int SW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [SW-1:0] PRE_MAX = SW'(CLK_PER_US - 1);

  logic [SW-1:0]                r_presc;
  logic                         w_tick;
  logic [NUM_LANES-1:0]         w_sig;
  logic [NUM_LANES-1:0][15:0]   w_width;

  assign w_sig = {Sig_In8, Sig_In7, Sig_In6, Sig_In5,
                  Sig_In4, Sig_In3, Sig_In2, Sig_In1};

  // Shared microsecond prescaler, held at zero while disabled.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                  r_presc <= '0;
    else if (!En)               r_presc <= '0;
    else if (r_presc == PRE_MAX) r_presc <= '0;
    else                        r_presc <= r_presc + 1'b1;
  end

  assign w_tick = En & (r_presc == PRE_MAX);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
    pwm_capture_ch #(
      .CLK_PER_US (CLK_PER_US),
      .MIN_US     (MIN_US),
      .MAX_US     (MAX_US),
      .TIMEOUT_US (TIMEOUT_US),
      .SW         (SW)
    ) u_ch (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .i_en     (En),
      .i_tick   (w_tick),
      .i_sig    (w_sig[g]),
      .o_width  (w_width[g]),
      .o_valid  (Valid[g]),
      .o_update (Update[g])
    );
  end

  assign Width1 = w_width[0];
  assign Width2 = w_width[1];
  assign Width3 = w_width[2];
  assign Width4 = w_width[3];
  assign Width5 = w_width[4];
  assign Width6 = w_width[5];
  assign Width7 = w_width[6];
  assign Width8 = w_width[7];

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture, run with a scaled time base (4 clocks per us,
// 20..100 us window, 400 us loss timeout) so every scenario stays short.
`timescale 1ns/1ps

module tb_pwm_capture;

  localparam int C   = 4;
  localparam int MIN = 20;
  localparam int MAX = 100;
  localparam int TMO = 400;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        En = 1'b0;
  logic [7:0]  sig = '0;
  logic [15:0] wact [8];
  logic [7:0]  Valid, Update;

  int n_tests = 0;
  int n_fail  = 0;
  int n_prt   = 0;

  pwm_capture #(.CLK_PER_US(C), .MIN_US(MIN), .MAX_US(MAX), .TIMEOUT_US(TMO)) dut (
    .CLK(CLK), .RSTn(RSTn), .En(En),
    .Sig_In1(sig[0]), .Sig_In2(sig[1]), .Sig_In3(sig[2]), .Sig_In4(sig[3]),
    .Sig_In5(sig[4]), .Sig_In6(sig[5]), .Sig_In7(sig[6]), .Sig_In8(sig[7]),
    .Width1(wact[0]), .Width2(wact[1]), .Width3(wact[2]), .Width4(wact[3]),
    .Width5(wact[4]), .Width6(wact[5]), .Width7(wact[6]), .Width8(wact[7]),
    .Valid(Valid), .Update(Update)
  );

  always #10 CLK = ~CLK;

  // Reference model: counts clock edges the pin was seen high while active,
  // rounds to microseconds on the fall and reports two edges later.
  int ecnt = 0;
  int run_n [8];
  int pend_e [8];
  int pend_m [8];
  int m_width [8];
  int m_last [8];
  bit m_valid [8];
  bit m_upd [8];

  initial begin
    for (int c = 0; c < 8; c++) begin
      run_n[c] = 0; pend_e[c] = -1; pend_m[c] = 0;
      m_width[c] = 0; m_last[c] = 0; m_valid[c] = 0; m_upd[c] = 0;
    end
  end

  always @(posedge CLK) begin
    ecnt = ecnt + 1;
    for (int c = 0; c < 8; c++) begin
      m_upd[c] = 0;
      if (!RSTn || !En) begin
        run_n[c] = 0; pend_e[c] = -1; m_valid[c] = 0; m_width[c] = 0;
      end else begin
        if (pend_e[c] == ecnt) begin
          pend_e[c] = -1;
          if (pend_m[c] >= MIN && pend_m[c] <= MAX) begin
            m_upd[c] = 1; m_width[c] = pend_m[c]; m_valid[c] = 1; m_last[c] = ecnt;
          end
        end
        if (sig[c]) run_n[c] = run_n[c] + 1;
        else if (run_n[c] > 0) begin
          pend_m[c] = (run_n[c] + C/2) / C;
          pend_e[c] = ecnt + 2;
          run_n[c] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every channel against the model.
  always @(negedge CLK) begin
    for (int c = 0; c < 8; c++) begin
      bit eu, ok;
      int age;
      eu = RSTn ? m_upd[c] : 1'b0;
      n_tests++;
      if (Update[c] !== eu) begin
        n_fail++;
        if (n_prt < 30) begin
          n_prt++;
          $display("FAIL upd ch%0d e%0d: got %b expected %b", c+1, ecnt, Update[c], eu);
        end
      end
      age = ecnt - m_last[c];
      if (!RSTn || !m_valid[c] || age >= (TMO+1)*C)
        ok = (Valid[c] === 1'b0) && (wact[c] === 16'd0);
      else if (age < (TMO-1)*C)
        ok = (Valid[c] === 1'b1) && (wact[c] === 16'(m_width[c]));
      else
        ok = ((Valid[c] === 1'b1) && (wact[c] === 16'(m_width[c]))) ||
             ((Valid[c] === 1'b0) && (wact[c] === 16'd0));
      n_tests++;
      if (!ok) begin
        n_fail++;
        if (n_prt < 30) begin
          n_prt++;
          $display("FAIL width/valid ch%0d e%0d: got w=%0d v=%b expected w=%0d v=%b age=%0d",
                   c+1, ecnt, wact[c], Valid[c], m_width[c], m_valid[c], age);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int ch, input int nhi, input int nlo);
    sig[ch] = 1'b1;
    cyc(nhi);
    sig[ch] = 1'b0;
    cyc(nlo);
  endtask

  int off [8];
  int wus [8];

  initial begin
    // Reset state
    cyc(3);
    @(negedge CLK);
    chk("reset Valid", 32'(Valid), 0);
    chk("reset Update", 32'(Update), 0);
    chk("reset Width1", 32'(wact[0]), 0);
    cyc(1);
    RSTn = 1'b1;
    En = 1'b1;
    cyc(5);

    // 60 us on ch1 with exact update latency
    sig[0] = 1'b1;
    cyc(240);
    sig[0] = 1'b0;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    chk("lat k+1 Update", 32'(Update), 0);
    @(posedge CLK); @(negedge CLK);
    chk("lat k+2 Update", 32'(Update), 32'h01);
    chk("lat k+2 Width1", 32'(wact[0]), 60);
    chk("lat k+2 Valid", 32'(Valid), 32'h01);
    chk("lat k+2 Width2", 32'(wact[1]), 0);
    @(posedge CLK); @(negedge CLK);
    chk("lat k+3 Update", 32'(Update), 0);
    cyc(5);

    // Rounding boundary
    pulse(0, 241, 10); chk("round +1clk", 32'(wact[0]), 60);
    pulse(0, 242, 10); chk("round +2clk", 32'(wact[0]), 61);

    // Acceptance window
    pulse(0, 160, 10); chk("good 40", 32'(wact[0]), 40);
    pulse(0, 76, 10);  chk("reject 19", 32'(wact[0]), 40);
    chk("reject 19 valid", 32'(Valid[0]), 1);
    pulse(0, 404, 10); chk("reject 101", 32'(wact[0]), 40);
    pulse(0, 80, 10);  chk("accept min", 32'(wact[0]), 20);
    pulse(0, 400, 10); chk("accept max", 32'(wact[0]), 100);

    // Loss-of-signal timeout on ch3
    pulse(2, 192, 3);
    cyc(1500);
    @(negedge CLK);
    chk("tmo before Valid3", 32'(Valid[2]), 1);
    chk("tmo before Width3", 32'(wact[2]), 48);
    cyc(200);
    @(negedge CLK);
    chk("tmo after Valid3", 32'(Valid[2]), 0);
    chk("tmo after Width3", 32'(wact[2]), 0);
    cyc(1);
    pulse(2, 176, 10);
    chk("restore Valid3", 32'(Valid[2]), 1);
    chk("restore Width3", 32'(wact[2]), 44);

    // All eight channels, skewed phases, ch1..ch4 falls coincident
    for (int c = 0; c < 8; c++) begin
      wus[c] = 40 + 4*c;
      off[c] = (c < 4) ? (3 - c) * 16 : c * 5;
    end
    for (int t = 0; t < 1200; t++) begin
      for (int c = 0; c < 8; c++)
        sig[c] = ((t % 400) >= off[c]) && ((t % 400) < off[c] + wus[c]*C);
      cyc(1);
    end
    sig = '0;
    cyc(5);
    chk("multi Valid", 32'(Valid), 32'hFF);
    chk("multi Width1", 32'(wact[0]), 40);
    chk("multi Width8", 32'(wact[7]), 68);

    // Reset mid-pulse on ch2
    sig[1] = 1'b1;
    cyc(100);
    RSTn = 1'b0;
    @(negedge CLK);
    chk("async rst Valid", 32'(Valid), 0);
    cyc(4);
    RSTn = 1'b1;
    cyc(40);
    sig[1] = 1'b0;
    cyc(10);
    chk("post rst Width2", 32'(wact[1]), 0);
    pulse(1, 288, 10);
    chk("post rst good", 32'(wact[1]), 72);

    // En drop mid-pulse on ch2
    sig[1] = 1'b1;
    cyc(100);
    En = 1'b0;
    @(negedge CLK);
    chk("en drop pre-edge Valid2", 32'(Valid[1]), 1);
    @(posedge CLK); @(negedge CLK);
    chk("en drop post-edge Valid", 32'(Valid), 0);
    chk("en drop post-edge Width2", 32'(wact[1]), 0);
    cyc(3);
    En = 1'b1;
    cyc(40);
    sig[1] = 1'b0;
    cyc(10);
    chk("post en Valid2", 32'(Valid[1]), 0);
    pulse(1, 300, 10);
    chk("post en good", 32'(wact[1]), 75);

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
